// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: opcodes, ASCII codes, FSM encoding.
// Small helpers classify received bytes.
package uart_cmd_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_PAUSE     = 3'd2;
  localparam logic [2:0] CMD_CANCEL    = 3'd3;
  localparam logic [2:0] CMD_SET_TIME  = 3'd4;
  localparam logic [2:0] CMD_SET_POWER = 3'd5;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_K     = 8'h4B;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_5     = 8'h35;
  localparam logic [7:0] ASCII_9     = 8'h39;

  typedef enum logic [2:0] {
    ST_OP   = 3'd0,
    ST_ARG  = 3'd1,
    ST_END  = 3'd2,
    ST_EXEC = 3'd3,
    ST_ACK  = 3'd4,
    ST_DISC = 3'd5
  } state_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of the RX FIFO, TX FIFO and decoded-command signals of uart_cmd_parser.
// master = parser side, slave = UART/controller side.
interface uart_cmd_parser_if;
  import uart_cmd_pkg::*;

  // Handshakes: rd_uart is a one-cycle pop of the RX FIFO head and is only raised when
  // rx_empty was low on that edge; wr_uart is a one-cycle push of w_data, only raised when
  // tx_full was low on that edge. cmd_valid/cmd_err are single-cycle strobes, never together.
  logic [7:0]  r_data;
  logic        rx_empty;
  logic        rd_uart;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] cmd_time;
  logic [3:0]  cmd_power;
  logic        cmd_err;
  state_t      dbg_state;

  modport master (
    input  r_data, rx_empty, tx_full,
    output rd_uart, w_data, wr_uart, cmd_valid, cmd_code, cmd_time, cmd_power, cmd_err,
           dbg_state
  );

  modport slave (
    output r_data, rx_empty, tx_full,
    input  rd_uart, w_data, wr_uart, cmd_valid, cmd_code, cmd_time, cmd_power, cmd_err,
           dbg_state
  );
endinterface

// File: rtl/uart_byte_fetch.sv
// RX FIFO reader: pops one byte when allowed, latches it and hands it to the parser
// as a one-cycle byte_valid strobe.
module uart_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_en,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  logic       rd_q;
  logic [7:0] data_q;
  logic       take;

  // The FIFO only advances on the edge after rd_uart, so the cycle with rd_q high
  // still shows the old head: never fetch back to back.
  assign take = fetch_en && !rx_empty && !rd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      rd_q <= take;
      if (take) data_q <= r_data;
    end
  end

  assign rd_uart    = rd_q;
  assign byte_valid = rd_q;
  assign byte_data  = data_q;
endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command-line decoder for the microwave controller (S, P, C, Tmmss, Ln).
// Define CMD_ACK_EN to answer each line with 'K' (accepted) or '?' (rejected) on the TX FIFO.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.master  bus
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t              state;
  logic                fetch_en;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                rd_uart;

  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_run;
  logic                 tmo_hit;

  logic [2:0]  op_q;
  logic [2:0]  dig_need;
  logic [2:0]  dig_idx;
  logic [15:0] arg_time;
  logic [3:0]  arg_power;
  logic        digit_ok;

  logic        cmd_valid_q;
  logic        cmd_err_q;
  logic [2:0]  cmd_code_q;
  logic [15:0] cmd_time_q;
  logic [3:0]  cmd_power_q;

`ifdef CMD_ACK_EN
  logic        wr_uart_q;
  logic [7:0]  ack_byte;
`endif

  uart_byte_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .rx_empty   (bus.rx_empty),
    .r_data     (bus.r_data),
    .rd_uart    (rd_uart),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  assign tmo_run = (state == ST_ARG) || (state == ST_END) || (state == ST_DISC);
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && tmo_run && !byte_valid && (tmo_cnt == TMO_LAST);

  // A byte that shows up on the timeout edge is left in the FIFO for the next line.
  assign fetch_en = (state != ST_EXEC) && (state != ST_ACK) && !tmo_hit;

  // Seconds tens digit is the third digit of Tmmss; power level 0 is not a level.
  always_comb begin
    digit_ok = is_digit(byte_data);
    if ((op_q == CMD_SET_TIME) && (dig_idx == 3'd2) && (byte_data > ASCII_5)) digit_ok = 1'b0;
    if ((op_q == CMD_SET_POWER) && (byte_data == ASCII_0)) digit_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_OP;
      tmo_cnt     <= '0;
      op_q        <= CMD_NONE;
      dig_need    <= 3'd0;
      dig_idx     <= 3'd0;
      arg_time    <= 16'h0000;
      arg_power   <= 4'h0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_code_q  <= CMD_NONE;
      cmd_time_q  <= 16'h0000;
      cmd_power_q <= 4'h0;
`ifdef CMD_ACK_EN
      wr_uart_q   <= 1'b0;
      ack_byte    <= 8'h00;
`endif
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
`ifdef CMD_ACK_EN
      wr_uart_q   <= 1'b0;
`endif
      if (!tmo_run || byte_valid) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state     <= ST_EXEC;
        cmd_err_q <= 1'b1;
      end else begin
        case (state)
          ST_OP: begin
            if (byte_valid && !is_term(byte_data)) begin
              dig_idx  <= 3'd0;
              arg_time <= 16'h0000;
              case (byte_data)
                ASCII_S: begin op_q <= CMD_START;     dig_need <= 3'd0; state <= ST_END; end
                ASCII_P: begin op_q <= CMD_PAUSE;     dig_need <= 3'd0; state <= ST_END; end
                ASCII_C: begin op_q <= CMD_CANCEL;    dig_need <= 3'd0; state <= ST_END; end
                ASCII_T: begin op_q <= CMD_SET_TIME;  dig_need <= 3'd4; state <= ST_ARG; end
                ASCII_L: begin op_q <= CMD_SET_POWER; dig_need <= 3'd1; state <= ST_ARG; end
                default: state <= ST_DISC;
              endcase
            end
          end
          ST_ARG: begin
            if (byte_valid) begin
              if (is_term(byte_data)) begin
                // The line already ended, so there is nothing left to discard.
                state     <= ST_EXEC;
                cmd_err_q <= 1'b1;
              end else if (!digit_ok) begin
                state <= ST_DISC;
              end else begin
                arg_time  <= {arg_time[11:0], byte_data[3:0]};
                arg_power <= byte_data[3:0];
                dig_idx   <= dig_idx + 3'd1;
                if (dig_idx + 3'd1 == dig_need) state <= ST_END;
              end
            end
          end
          ST_END: begin
            if (byte_valid) begin
              if (is_term(byte_data)) begin
                state       <= ST_EXEC;
                cmd_valid_q <= 1'b1;
                cmd_code_q  <= op_q;
                if (op_q == CMD_SET_TIME)  cmd_time_q  <= arg_time;
                if (op_q == CMD_SET_POWER) cmd_power_q <= arg_power;
              end else begin
                state <= ST_DISC;
              end
            end
          end
          ST_DISC: begin
            if (byte_valid && is_term(byte_data)) begin
              state     <= ST_EXEC;
              cmd_err_q <= 1'b1;
            end
          end
          ST_EXEC: begin
`ifdef CMD_ACK_EN
            ack_byte <= cmd_valid_q ? ASCII_K : ASCII_QMARK;
            state    <= ST_ACK;
`else
            state <= ST_OP;
`endif
          end
          ST_ACK: begin
`ifdef CMD_ACK_EN
            if (!bus.tx_full) begin
              wr_uart_q <= 1'b1;
              state     <= ST_OP;
            end
`else
            state <= ST_OP;
`endif
          end
          default: state <= ST_OP;
        endcase
      end
    end
  end

  assign bus.rd_uart   = rd_uart;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_time  = cmd_time_q;
  assign bus.cmd_power = cmd_power_q;
  assign bus.dbg_state = state;
`ifdef CMD_ACK_EN
  assign bus.wr_uart   = wr_uart_q;
  assign bus.w_data    = ack_byte;
`else
  assign bus.wr_uart   = 1'b0;
  assign bus.w_data    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: behavioural RX FIFO, table of command lines with a
// reference model feeding an expected-event queue, plus timeout/reset/ack sequences.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(100), .TIMEOUT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int rd_cnt    = 0;
  int last_rd_cyc = 0;
  int err_cyc   = 0;
  logic prev_empty = 1'b1;
  logic prev_full  = 1'b0;
  logic prev_wr    = 1'b0;

  logic [7:0]  rx_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  ack_q[$];

  logic [2:0]  mdl_code  = 3'd0;
  logic [15:0] mdl_time  = 16'h0;
  logic [3:0]  mdl_power = 4'h0;

  typedef struct {
    string       line;
    bit          ev;
    bit          err;
    logic [2:0]  code;
    logic [15:0] tm;
    logic [3:0]  pw;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- RX FIFO model ----------------
  always @(negedge clk) begin
    if (bus.rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
    bus.rx_empty = (rx_q.size() == 0);
    bus.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    cyc++;
    prev_empty = bus.rx_empty;
    prev_full  = bus.tx_full;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst) begin
      if (bus.rd_uart) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        chk("rd_when_empty", {31'd0, prev_empty}, 32'd0);
      end
      if (bus.cmd_valid || bus.cmd_err) begin
        if (bus.cmd_err) err_cyc = cyc;
        chk("strobe_exclusive", {31'd0, bus.cmd_valid & bus.cmd_err}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_strobe", exp_q.size(), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("cmd_event", {8'd0, bus.cmd_err, bus.cmd_code, bus.cmd_time, bus.cmd_power},
              {8'd0, e});
        end
      end
`ifdef CMD_ACK_EN
      if (bus.wr_uart) begin
        chk("wr_while_full", {31'd0, prev_full}, 32'd0);
        chk("wr_one_cycle", {31'd0, prev_wr}, 32'd0);
        if (ack_q.size() == 0) chk("unexpected_ack", ack_q.size(), 32'd1);
        else chk("ack_byte", {24'd0, bus.w_data}, {24'd0, ack_q.pop_front()});
      end
`else
      if (bus.wr_uart || bus.w_data != 8'h00)
        chk("ack_tied_off", {23'd0, bus.wr_uart, bus.w_data}, 32'd0);
`endif
      prev_wr = bus.wr_uart;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_ev(input bit err);
    exp_q.push_back({err, mdl_code, mdl_time, mdl_power});
`ifdef CMD_ACK_EN
    ack_q.push_back(err ? 8'h3F : 8'h4B);
`endif
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_q.push_back(s[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || ack_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("drain_in_time", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic add(input string l, input bit ev, input bit err, input logic [2:0] c,
                     input logic [15:0] t, input logic [3:0] p);
    vec_t v;
    v.line = l; v.ev = ev; v.err = err; v.code = c; v.tm = t; v.pw = p;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total_cnt, pass_cnt);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int rd_before;
    bus.tx_full = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("rst_cmd_err",   {31'd0, bus.cmd_err},   32'd0);
    chk("rst_cmd_code",  {29'd0, bus.cmd_code},  32'd0);
    chk("rst_cmd_time",  {16'd0, bus.cmd_time},  32'd0);
    chk("rst_cmd_power", {28'd0, bus.cmd_power}, 32'd0);
    chk("rst_rd_uart",   {31'd0, bus.rd_uart},   32'd0);
    chk("rst_wr_uart",   {31'd0, bus.wr_uart},   32'd0);
    chk("rst_w_data",    {24'd0, bus.w_data},    32'd0);
    chk("rst_state",     32'(bus.dbg_state),     32'(ST_OP));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    add("T0130\r", 1, 0, CMD_SET_TIME,  16'h0130, 4'h0);
    add("L7\n",    1, 0, CMD_SET_POWER, 16'h0,    4'h7);
    add("S\r",     1, 0, CMD_START,     16'h0,    4'h0);
    add("T0175\r", 1, 1, 3'd0, 16'h0, 4'h0);
    add("X\r",     1, 1, 3'd0, 16'h0, 4'h0);
    add("L0\r",    1, 1, 3'd0, 16'h0, 4'h0);
    add("SS\r",    1, 1, 3'd0, 16'h0, 4'h0);
    add("\r",      0, 0, 3'd0, 16'h0, 4'h0);
    add("P\n",     1, 0, CMD_PAUSE,     16'h0,    4'h0);
    add("T59\r",   1, 1, 3'd0, 16'h0, 4'h0);
    add("T2359\n", 1, 0, CMD_SET_TIME,  16'h2359, 4'h0);
    add("t\r",     1, 1, 3'd0, 16'h0, 4'h0);
    add("T12a4\r", 1, 1, 3'd0, 16'h0, 4'h0);
    add("L12\r",   1, 1, 3'd0, 16'h0, 4'h0);
    add("T0060\r", 1, 1, 3'd0, 16'h0, 4'h0);
    add("L9\r",    1, 0, CMD_SET_POWER, 16'h0,    4'h9);
    add("\n",      0, 0, 3'd0, 16'h0, 4'h0);
    add("T9959\r", 1, 0, CMD_SET_TIME,  16'h9959, 4'h0);
    add("C\r",     1, 0, CMD_CANCEL,    16'h0,    4'h0);

    foreach (vecs[i]) begin
      if (vecs[i].ev) begin
        if (!vecs[i].err) begin
          mdl_code = vecs[i].code;
          if (vecs[i].code == CMD_SET_TIME)  mdl_time  = vecs[i].tm;
          if (vecs[i].code == CMD_SET_POWER) mdl_power = vecs[i].pw;
        end
        expect_ev(vecs[i].err);
      end
      send_line(vecs[i].line);
      drain();
      chk("idle_state", 32'(bus.dbg_state), 32'(ST_OP));
    end

    // Partial line then silence: inter-byte timeout aborts it.
    expect_ev(1'b1);
    send_line("T01");
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_fired", {31'd0, n < 300}, 32'd1);
    chk("timeout_latency_window",
        {31'd0, (err_cyc - last_rd_cyc >= 99) && (err_cyc - last_rd_cyc <= 103)}, 32'd1);
    drain();
    mdl_code = CMD_CANCEL;
    expect_ev(1'b0);
    send_line("C\r");
    drain();

`ifdef CMD_ACK_EN
    // TX FIFO full: ack stalls and no further bytes are fetched meanwhile.
    bus.tx_full = 1'b1;
    mdl_code = CMD_PAUSE;
    expect_ev(1'b0);
    send_line("P\r");
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ack_cmd_seen", {31'd0, n < 100}, 32'd1);
    rd_before = rd_cnt;
    mdl_code = CMD_START;
    expect_ev(1'b0);
    send_line("S\r");
    repeat (20) @(negedge clk);
    chk("no_fetch_in_ack", rd_cnt - rd_before, 32'd0);
    chk("ack_wdata_held", {24'd0, bus.w_data}, 32'h4B);
    chk("ack_pending", ack_q.size(), 32'd2);
    chk("ack_wait_state", 32'(bus.dbg_state), 32'(ST_ACK));
    bus.tx_full = 1'b0;
    drain();
`endif

    // Reset in the middle of a line drops it and clears the outputs.
    send_line("T01");
    while (rx_q.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_cmd_code",  {29'd0, bus.cmd_code},  32'd0);
    chk("mid_rst_cmd_time",  {16'd0, bus.cmd_time},  32'd0);
    chk("mid_rst_cmd_power", {28'd0, bus.cmd_power}, 32'd0);
    chk("mid_rst_state",     32'(bus.dbg_state),     32'(ST_OP));
    rst = 1'b1;
    mdl_code = 3'd0; mdl_time = 16'h0; mdl_power = 4'h0;
    send_line("\r");
    drain();
    mdl_code = CMD_START;
    expect_ev(1'b0);
    send_line("S\r");
    drain();
    chk("final_cmd_code", {29'd0, bus.cmd_code}, {29'd0, CMD_START});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
